video_timing_rx: RTL

Video timing receiver and analyser. It consumes a raw blank/sync stream and recovers pixel and line counters aligned to the first active pixel. It measures horizontal and vertical active/total lengths and declares lock after consecutive identical frames. It sits downstream of any video source, such as the core's timing generator or an external feed, and drives scalers, OSD and capture logic that need a stable timing description.

---
 rtl/video_timing_rx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_rx.sv
// rtl/video_timing_rx.sv - blank/sync timing receiver: counters, measurements, lock tracking
// Optional sync measurements enabled by defining VIDEO_TIMING_RX_SYNC_MEAS_EN.
module video_timing_rx #(
    parameter int W           = 9,
    parameter int LOCK_FRAMES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hbl,
    input  logic         hsync,
    input  logic         vbl,
    input  logic         vsync,
    output logic [W-1:0] hc,
    output logic [W-1:0] vc,
    output logic [W-1:0] hactive,
    output logic [W-1:0] htotal,
    output logic [W-1:0] vactive,
    output logic [W-1:0] vtotal,
    output logic         frame_start,
    output logic         locked,
    output logic         err,
    output logic [W-1:0] hs_start,
    output logic [W-1:0] hs_width,
    output logic [W-1:0] vs_start,
    output logic [W-1:0] vs_width
);

    localparam logic [W-1:0] MAX = '1;
    localparam int CW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state, state_nxt;
    logic          hbl_q, vbl_q, pending, h_ovf, v_ovf;
    logic          line_start, hbl_rise, vbl_fall, vbl_rise, frame_evt;
    logic [W-1:0]  hc_inc, vc_inc;
    logic [W-1:0]  snap_h, snap_h_nxt, snap_v, snap_v_nxt;
    logic          snap_valid, snap_valid_nxt, err_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;

    assign line_start = hbl_q & ~hbl;
    assign hbl_rise   = ~hbl_q & hbl;
    assign vbl_fall   = vbl_q & ~vbl;
    assign vbl_rise   = ~vbl_q & vbl;
    assign frame_evt  = line_start & (pending | vbl_fall);
    assign hc_inc     = hc + 1'b1;
    assign vc_inc     = vc + 1'b1;
    assign cnt_inc    = cnt + 1'b1;

    // Overflow flags are single-cycle: they re-assert every clock the counter stays pinned.
    always_ff @(posedge clk) begin
        if (reset) begin
            hbl_q       <= 1'b0;
            vbl_q       <= 1'b0;
            pending     <= 1'b0;
            h_ovf       <= 1'b0;
            v_ovf       <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            hactive     <= '0;
            htotal      <= '0;
            vactive     <= '0;
            vtotal      <= '0;
            frame_start <= 1'b0;
        end else begin
            hbl_q       <= hbl;
            vbl_q       <= vbl;
            frame_start <= frame_evt;
            h_ovf       <= 1'b0;
            v_ovf       <= 1'b0;
            if (line_start) begin
                hc     <= '0;
                htotal <= hc_inc;
            end else if (hc == MAX) begin
                h_ovf <= 1'b1;
            end else begin
                hc <= hc_inc;
            end
            if (hbl_rise)
                hactive <= hc_inc;
            if (frame_evt) begin
                vc      <= '0;
                vtotal  <= vc_inc;
                pending <= 1'b0;
            end else begin
                if (line_start) begin
                    if (vc == MAX)
                        v_ovf <= 1'b1;
                    else
                        vc <= vc_inc;
                end
                if (vbl_fall)
                    pending <= 1'b1;
            end
            if (vbl_rise)
                vactive <= vc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            snap_h     <= '0;
            snap_v     <= '0;
            snap_valid <= 1'b0;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            snap_h     <= snap_h_nxt;
            snap_v     <= snap_v_nxt;
            snap_valid <= snap_valid_nxt;
            cnt        <= cnt_nxt;
            err        <= err_nxt;
        end
    end

    // Snapshots compare the totals being captured this cycle, not the stale registers.
    always_comb begin
        state_nxt      = state;
        snap_h_nxt     = snap_h;
        snap_v_nxt     = snap_v;
        snap_valid_nxt = snap_valid;
        cnt_nxt        = cnt;
        err_nxt        = 1'b0;
        if (h_ovf || v_ovf) begin
            state_nxt = SEARCH;
            err_nxt   = (state == LOCKED);
        end else begin
            case (state)
                SEARCH: begin
                    if (frame_evt) begin
                        state_nxt      = VERIFY;
                        snap_valid_nxt = 1'b0;
                    end
                end
                VERIFY: begin
                    if (frame_evt) begin
                        if (snap_valid && hc_inc == snap_h && vc_inc == snap_v) begin
                            cnt_nxt = cnt_inc;
                            if (cnt_inc == CW'(LOCK_FRAMES))
                                state_nxt = LOCKED;
                        end else begin
                            snap_h_nxt     = hc_inc;
                            snap_v_nxt     = vc_inc;
                            snap_valid_nxt = 1'b1;
                            cnt_nxt        = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (line_start && (hc_inc != snap_h || (frame_evt && vc_inc != snap_v))) begin
                        err_nxt   = 1'b1;
                        state_nxt = SEARCH;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

`ifdef VIDEO_TIMING_RX_SYNC_MEAS_EN
    logic         hsync_q, vsync_q;
    logic [W-1:0] hs_cnt, vs_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hs_cnt   <= '0;
            vs_cnt   <= '0;
            hs_start <= '0;
            hs_width <= '0;
            vs_start <= '0;
            vs_width <= '0;
        end else begin
            hsync_q <= hsync;
            vsync_q <= vsync;
            if (hsync_q && !hsync) begin
                hs_start <= hc_inc;
                hs_cnt   <= {{(W-1){1'b0}}, 1'b1};
            end else if (!hsync_q && !hsync) begin
                hs_cnt <= hs_cnt + 1'b1;
            end
            if (!hsync_q && hsync)
                hs_width <= hs_cnt;
            if (vsync_q && !vsync) begin
                vs_start <= vc_inc;
                vs_cnt   <= {{(W-1){1'b0}}, line_start};
            end else if (!vsync_q && !vsync && line_start) begin
                vs_cnt <= vs_cnt + 1'b1;
            end
            if (!vsync_q && vsync)
                vs_width <= vs_cnt;
        end
    end
`else
    logic sync_unused;
    assign sync_unused = hsync ^ vsync;
    assign hs_start    = '0;
    assign hs_width    = '0;
    assign vs_start    = '0;
    assign vs_width    = '0;
`endif

endmodule
